tube_scan_driver: RTL and testbench

Multiplexed N-digit seven-segment display driver for the taximeter front panel. It accepts packed BCD digits and decimal points and time-multiplexes them onto one shared segment bus with one-hot digit selects. It adds double-buffered loading, leading-zero blanking, anti-ghosting blanking and configurable output polarity. It sits between the fare/distance formatting logic and the board display pins.

---
 rtl/tube_pkg.sv | 36 +++
 rtl/tube_scan_driver_if.sv | 22 ++
 rtl/tube_scan_driver_seg7_encode.sv | 29 ++
 rtl/tube_scan_driver.sv | 145 ++++++++++++++
 tb/tb_tube_scan_driver.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/tube_pkg.sv
// Shared seven-segment code table and BCD decoder for the front-panel display blocks.
// Segment words are in active-high form, bit order g..a.
package tube_pkg;

   localparam logic [6:0] SEG_0     = 7'h3F;
   localparam logic [6:0] SEG_1     = 7'h06;
   localparam logic [6:0] SEG_2     = 7'h5B;
   localparam logic [6:0] SEG_3     = 7'h4F;
   localparam logic [6:0] SEG_4     = 7'h66;
   localparam logic [6:0] SEG_5     = 7'h6D;
   localparam logic [6:0] SEG_6     = 7'h7D;
   localparam logic [6:0] SEG_7     = 7'h07;
   localparam logic [6:0] SEG_8     = 7'h7F;
   localparam logic [6:0] SEG_9     = 7'h6F;
   localparam logic [6:0] SEG_BLANK = 7'h00;

   // Codes 10-15 are not digits and render dark.
   function automatic logic [6:0] bcd_to_seg(input logic [3:0] i_code);
      logic [6:0] r;
      case (i_code)
         4'd0:    r = SEG_0;
         4'd1:    r = SEG_1;
         4'd2:    r = SEG_2;
         4'd3:    r = SEG_3;
         4'd4:    r = SEG_4;
         4'd5:    r = SEG_5;
         4'd6:    r = SEG_6;
         4'd7:    r = SEG_7;
         4'd8:    r = SEG_8;
         4'd9:    r = SEG_9;
         default: r = SEG_BLANK;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/tube_scan_driver_if.sv
// Bundle between the fare/distance formatter (master) and the scan driver (slave).
interface tube_scan_driver_if #(
   parameter int DIGITS = 4
);
   logic                  enable;
   logic [4*DIGITS-1:0]   digits_in;
   logic [DIGITS-1:0]     dp_in;
   logic                  load;
   logic [7:0]            seg_out;
   logic [DIGITS-1:0]     sel_out;
   logic                  frame_done;

   modport master (
      output enable, digits_in, dp_in, load,
      input  seg_out, sel_out, frame_done
   );

   modport slave (
      input  enable, digits_in, dp_in, load,
      output seg_out, sel_out, frame_done
   );
endinterface

// File: rtl/tube_scan_driver_seg7_encode.sv
// Combinational seven-segment encoder: BCD code, dp, blank request and polarity to a pin word.
module seg7_encode
   import tube_pkg::*;
(
   input  logic [3:0] i_code,
   input  logic       i_dp,
   input  logic       i_blank,
   input  logic       i_active_high,
   output logic [7:0] o_seg
);

   logic [7:0] w_raw;

   // Blanking only clears the digit segments; the decimal point survives.
   always_comb begin
      w_raw = 8'h00;
      if (i_blank) begin
         w_raw = {i_dp, SEG_BLANK};
      end else begin
         w_raw = {i_dp, bcd_to_seg(i_code)};
      end
      if (i_active_high) begin
         o_seg = w_raw;
      end else begin
         o_seg = ~w_raw;
      end
   end

endmodule

// File: rtl/tube_scan_driver.sv
// Multiplexed seven-segment scan driver with double-buffered digit loading,
// leading-zero suppression and anti-ghost blanking at the start of every dwell.
module tube_scan_driver
   import tube_pkg::*;
#(
   parameter int DIGITS          = 4,
   parameter int SCAN_DIV        = 50000,
   parameter int BLANK_CYCLES    = 2,
   parameter int SEG_ACTIVE_HIGH = 1,
   parameter int SEL_ACTIVE_HIGH = 0,
   parameter int BLANK_LEADING   = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   tube_scan_driver_if.slave   bus
);

   localparam int CNT_W = $clog2(SCAN_DIV);
   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [7:0]        SEG_OFF = (SEG_ACTIVE_HIGH != 0) ? {1'b0, SEG_BLANK} : ~{1'b0, SEG_BLANK};
   localparam logic [DIGITS-1:0] SEL_OFF = (SEL_ACTIVE_HIGH != 0) ? {DIGITS{1'b0}} : {DIGITS{1'b1}};

   logic [CNT_W-1:0]        r_scan_cnt;
   logic [IDX_W-1:0]        r_idx;
   logic [DIGITS-1:0][3:0]  r_staging;
   logic [DIGITS-1:0]       r_staging_dp;
   logic [DIGITS-1:0][3:0]  r_shadow;
   logic [DIGITS-1:0]       r_shadow_dp;
   logic                    r_pending;
   logic [7:0]              r_seg;
   logic [DIGITS-1:0]       r_sel;
   logic                    r_wrap_q;
   logic                    r_frame_done;

   logic                    w_last_cnt;
   logic                    w_last_idx;
   logic                    w_wrap;
   logic                    w_xfer;
   logic [DIGITS-1:0]       w_lz;
   logic                    w_zero_above;
   logic [DIGITS-1:0]       w_sel_onehot;
   logic [7:0]              w_seg;

   assign w_last_cnt = (r_scan_cnt == CNT_W'(SCAN_DIV - 1));
   assign w_last_idx = (r_idx == IDX_W'(DIGITS - 1));
   assign w_wrap     = bus.enable & w_last_cnt & w_last_idx;
   // While dark there is no frame to tear, so the shadow may update on any edge.
   assign w_xfer     = r_pending & (~bus.enable | w_wrap);

   // Leading-zero mask: walk down from the top digit while every digit seen so far is zero.
   always_comb begin
      w_lz         = {DIGITS{1'b0}};
      w_zero_above = 1'b1;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         w_zero_above = w_zero_above & (r_shadow[i] == 4'd0);
         if ((i > 0) && (BLANK_LEADING != 0)) begin
            w_lz[i] = w_zero_above;
         end else begin
            w_lz[i] = 1'b0;
         end
      end
   end

   // Select for the current digit, held off during the anti-ghost window.
   always_comb begin
      w_sel_onehot = {DIGITS{1'b0}};
      if (r_scan_cnt >= CNT_W'(BLANK_CYCLES)) begin
         w_sel_onehot[r_idx] = 1'b1;
      end else begin
         w_sel_onehot = {DIGITS{1'b0}};
      end
   end

   seg7_encode u_encode (
      .i_code        (r_shadow[r_idx]),
      .i_dp          (r_shadow_dp[r_idx]),
      .i_blank       (w_lz[r_idx]),
      .i_active_high (SEG_ACTIVE_HIGH != 0),
      .o_seg         (w_seg)
   );

   // Dwell counter and digit index.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_scan_cnt <= {CNT_W{1'b0}};
         r_idx      <= {IDX_W{1'b0}};
      end else if (!bus.enable) begin
         r_scan_cnt <= {CNT_W{1'b0}};
         r_idx      <= {IDX_W{1'b0}};
      end else if (w_last_cnt) begin
         r_scan_cnt <= {CNT_W{1'b0}};
         r_idx      <= w_last_idx ? {IDX_W{1'b0}} : r_idx + IDX_W'(1);
      end else begin
         r_scan_cnt <= r_scan_cnt + CNT_W'(1);
      end
   end

   // Staging/shadow double buffer; a load coinciding with a transfer keeps pending set.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_staging    <= '0;
         r_staging_dp <= {DIGITS{1'b0}};
         r_shadow     <= '0;
         r_shadow_dp  <= {DIGITS{1'b0}};
         r_pending    <= 1'b0;
      end else begin
         if (w_xfer) begin
            r_shadow    <= r_staging;
            r_shadow_dp <= r_staging_dp;
         end
         if (bus.load) begin
            r_staging    <= bus.digits_in;
            r_staging_dp <= bus.dp_in;
            r_pending    <= 1'b1;
         end else if (w_xfer) begin
            r_pending <= 1'b0;
         end
      end
   end

   // Registered pins; frame_done is delayed twice so it lands with digit 0's first output.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_seg        <= SEG_OFF;
         r_sel        <= SEL_OFF;
         r_wrap_q     <= 1'b0;
         r_frame_done <= 1'b0;
      end else if (!bus.enable) begin
         r_seg        <= SEG_OFF;
         r_sel        <= SEL_OFF;
         r_wrap_q     <= 1'b0;
         r_frame_done <= 1'b0;
      end else begin
         r_seg        <= w_seg;
         r_sel        <= (SEL_ACTIVE_HIGH != 0) ? w_sel_onehot : ~w_sel_onehot;
         r_wrap_q     <= w_wrap;
         r_frame_done <= r_wrap_q;
      end
   end

   assign bus.seg_out    = r_seg;
   assign bus.sel_out    = r_sel;
   assign bus.frame_done = r_frame_done;

endmodule

// File: tb/tb_tube_scan_driver.sv
// Bench for tube_scan_driver: two instances (segment polarity high and low) share one stimulus
// and are compared each cycle against a frame-position model, plus literal frame tables.
module tb_tube_scan_driver;

   localparam int D  = 4;
   localparam int SD = 4;
   localparam int BC = 1;

   logic clk = 1'b0;
   logic rst_n;

   tube_scan_driver_if #(.DIGITS(D)) if_a ();
   tube_scan_driver_if #(.DIGITS(D)) if_b ();

   assign if_b.enable    = if_a.enable;
   assign if_b.digits_in = if_a.digits_in;
   assign if_b.dp_in     = if_a.dp_in;
   assign if_b.load      = if_a.load;

   tube_scan_driver #(
      .DIGITS(D), .SCAN_DIV(SD), .BLANK_CYCLES(BC),
      .SEG_ACTIVE_HIGH(1), .SEL_ACTIVE_HIGH(0), .BLANK_LEADING(1)
   ) dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a.slave));

   tube_scan_driver #(
      .DIGITS(D), .SCAN_DIV(SD), .BLANK_CYCLES(BC),
      .SEG_ACTIVE_HIGH(0), .SEL_ACTIVE_HIGH(0), .BLANK_LEADING(1)
   ) dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b.slave));

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
      end
   endtask

   // Model: position in the frame is a single cycle count since enable rose.
   logic [6:0]  m_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};
   int          m_t        = 0;
   logic [15:0] m_staging  = 16'h0;
   logic [3:0]  m_stg_dp   = 4'h0;
   logic [15:0] m_shadow   = 16'h0;
   logic [3:0]  m_sh_dp    = 4'h0;
   logic        m_pending  = 1'b0;
   logic        m_wrap_prev = 1'b0;
   logic [7:0]  exp_seg    = 8'h00;
   logic [3:0]  exp_sel    = 4'hF;
   logic        exp_fd     = 1'b0;
   logic        m_wrap;
   logic        m_xfer;

   function automatic logic [7:0] m_seg(input logic [15:0] sh, input logic [3:0] dp, input int i);
      logic [6:0]  s;
      logic [15:0] upper;
      s     = m_tab[sh[4*i +: 4]];
      upper = sh >> (4 * i);
      if (i > 0 && upper == 16'h0) s = 7'h00;
      return {dp[i], s};
   endfunction

   assign m_wrap = if_a.enable && (m_t == SD * D - 1);
   assign m_xfer = m_pending && (!if_a.enable || m_wrap);

   // Model state update on each active edge.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_t <= 0; m_staging <= 16'h0; m_stg_dp <= 4'h0; m_shadow <= 16'h0; m_sh_dp <= 4'h0;
         m_pending <= 1'b0; m_wrap_prev <= 1'b0;
         exp_seg <= 8'h00; exp_sel <= 4'hF; exp_fd <= 1'b0;
      end else begin
         if (if_a.enable) begin
            exp_sel     <= ((m_t % SD) < BC) ? 4'hF : ~(4'b0001 << ((m_t / SD) % D));
            exp_seg     <= m_seg(m_shadow, m_sh_dp, (m_t / SD) % D);
            exp_fd      <= m_wrap_prev;
            m_wrap_prev <= m_wrap;
            m_t         <= (m_t + 1) % (SD * D);
         end else begin
            exp_sel <= 4'hF; exp_seg <= 8'h00; exp_fd <= 1'b0;
            m_wrap_prev <= 1'b0; m_t <= 0;
         end
         if (m_xfer) begin
            m_shadow <= m_staging;
            m_sh_dp  <= m_stg_dp;
         end
         if (if_a.load) begin
            m_staging <= if_a.digits_in; m_stg_dp <= if_a.dp_in; m_pending <= 1'b1;
         end else if (m_xfer) begin
            m_pending <= 1'b0;
         end
      end
   end

   // Every-cycle comparison of both instances against the model.
   always @(negedge clk) begin
      chk("a_seg", if_a.seg_out, exp_seg);
      chk("a_sel", if_a.sel_out, exp_sel);
      chk("a_fd",  if_a.frame_done, exp_fd);
      chk("b_seg", if_b.seg_out, 8'(~exp_seg));
      chk("b_sel", if_b.sel_out, exp_sel);
      chk("b_fd",  if_b.frame_done, exp_fd);
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_load(input logic [15:0] d, input logic [3:0] p);
      if_a.digits_in = d; if_a.dp_in = p; if_a.load = 1'b1;
      @(negedge clk);
      if_a.load = 1'b0;
   endtask

   task automatic wait_fd(input string nm);
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (if_a.frame_done === 1'b1) break;
      end
      chk(nm, if_a.frame_done, 1'b1);
   endtask

   // Starting on a frame_done cycle, walk one full frame against hand-written segment words.
   task automatic check_frame(input string nm, input logic [7:0] s0, input logic [7:0] s1,
                              input logic [7:0] s2, input logic [7:0] s3);
      logic [7:0] s [4];
      logic [3:0] es;
      int         d;
      s = '{s0, s1, s2, s3};
      for (int c = 0; c < 16; c++) begin
         d  = c / 4;
         es = (c % 4 == 0) ? 4'hF : 4'(~(4'b0001 << d));
         chk({nm, "_sel"}, if_a.sel_out, es);
         chk({nm, "_seg"}, if_a.seg_out, s[d]);
         chk({nm, "_fd"},  if_a.frame_done, (c == 0) ? 1'b1 : 1'b0);
         @(negedge clk);
      end
      chk({nm, "_period"}, if_a.frame_done, 1'b1);
   endtask

   initial begin
      rst_n = 1'b0;
      if_a.enable = 1'b0; if_a.load = 1'b0; if_a.digits_in = 16'h0; if_a.dp_in = 4'h0;
      tick(3);
      chk("rst_seg", if_a.seg_out, 8'h00);
      chk("rst_sel", if_a.sel_out, 4'hF);
      chk("rst_fd",  if_a.frame_done, 1'b0);
      rst_n = 1'b1;
      tick(2);
      chk("idle_seg", if_a.seg_out, 8'h00);
      chk("idle_sel", if_a.sel_out, 4'hF);

      do_load(16'h1234, 4'b0100);
      tick(1);
      if_a.enable = 1'b1;
      wait_fd("fd_1234");
      check_frame("f1234", 8'h66, 8'h4F, 8'hDB, 8'h06);

      do_load(16'h0070, 4'h0);
      wait_fd("fd_0070");
      check_frame("f0070", 8'h3F, 8'h07, 8'h00, 8'h00);
      do_load(16'h0000, 4'h0);
      wait_fd("fd_0000");
      check_frame("f0000", 8'h3F, 8'h00, 8'h00, 8'h00);

      tick(5);
      do_load(16'h5678, 4'h0);
      wait_fd("fd_5678");
      chk("b_eight", if_b.seg_out, 8'h80);
      check_frame("f5678", 8'h7F, 8'h07, 8'h7D, 8'h6D);

      tick(2);
      do_load(16'h1111, 4'h0);
      tick(3);
      do_load(16'h9999, 4'h0);
      wait_fd("fd_9999");
      check_frame("f9999", 8'h6F, 8'h6F, 8'h6F, 8'h6F);

      do_load(16'hFEDC, 4'h0);
      wait_fd("fd_fedc");
      chk("b_blank", if_b.seg_out, 8'hFF);
      check_frame("ffedc", 8'h00, 8'h00, 8'h00, 8'h00);
      do_load(16'h1AB0, 4'h0);
      wait_fd("fd_1ab0");
      check_frame("f1ab0", 8'h3F, 8'h00, 8'h00, 8'h06);

      tick(6);
      if_a.enable = 1'b0;
      tick(1);
      chk("dark_seg", if_a.seg_out, 8'h00);
      chk("dark_sel", if_a.sel_out, 4'hF);
      chk("dark_fd",  if_a.frame_done, 1'b0);
      chk("dark_bseg", if_b.seg_out, 8'hFF);
      tick(3);
      if_a.enable = 1'b1;
      tick(7);

      @(posedge clk);
      #2;
      rst_n = 1'b0;
      if_a.enable = 1'b0;
      #1;
      chk("arst_seg",  if_a.seg_out, 8'h00);
      chk("arst_sel",  if_a.sel_out, 4'hF);
      chk("arst_fd",   if_a.frame_done, 1'b0);
      chk("arst_bseg", if_b.seg_out, 8'hFF);
      tick(2);
      rst_n = 1'b1;
      tick(1);
      if_a.enable = 1'b1;
      tick(1);
      chk("restart_blank_sel", if_a.sel_out, 4'hF);
      chk("restart_seg", if_a.seg_out, 8'h3F);
      tick(1);
      chk("restart_dig0_sel", if_a.sel_out, 4'hE);
      tick(20);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
